fetch_prefetch: RTL

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_prefetch_if.sv | 36 +++
 rtl/fetch_queue.sv | 75 +++++++
 rtl/fetch_prefetch.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch unit.
//   pc_sel_e      : redirect source encoding on pc_sel.
//   fetch_state_e : prefetch control FSM states.
//   is_jump_sel() : true for the pc_sel codes that actually redirect.
package fetch_pkg;

    typedef enum logic [1:0] {
        PcSeq  = 2'b00,
        PcAlu  = 2'b01,
        PcImm  = 2'b10,
        PcRsvd = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        StBoot   = 2'b00,
        StRun    = 2'b01,
        StHalted = 2'b10
    } fetch_state_e;

    // Reserved code behaves like sequential, so only ALU/IMM redirect.
    function automatic logic is_jump_sel(logic [1:0] sel);
        return (sel == PcAlu) || (sel == PcImm);
    endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Bus bundle between the prefetch unit, instruction memory and decode.
//   imem_req/imem_addr/imem_rdata : synchronous memory read (data one cycle after req).
//   instr_valid/instr_ready/instr_data/instr_pc : decode handshake.
// master = prefetch unit, slave = memory + decode side.
interface fetch_prefetch_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instruction} entries.
//   clk, rst_n : clock, async active-low reset
//   flush      : empty the queue; wins over push and pop
//   push/wdata : write an entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : head entry, count : occupancy, empty : count == 0
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 43,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CntW-1:0]  count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: issues sequential reads to a synchronous
// instruction memory, buffers responses in a small queue and presents them
// to decode with their word address. Redirects flush the queue and restart
// fetch at the target.
//   clk, rst_n            : clock, async active-low reset
//   pc_sel, redirect      : redirect source and qualifier
//   alu_addr, imm_addr    : redirect targets
//   halt                  : stop issuing requests (queue still drains)
//   queue_count           : current queue occupancy
//   bus (master)          : memory request/response and decode handshake
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned RESET_PC    = 0,
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            pc_sel,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [ADDR_WIDTH-1:0] imm_addr,
    input  logic                  halt,
    output logic [CntW-1:0]       queue_count,
    fetch_prefetch_if.master      bus
);

    localparam int unsigned EntryW = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  in_flight_q, in_flight_d;
    logic [ADDR_WIDTH-1:0] tag_q, tag_d;

    logic                  jump;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [CntW:0]         occupancy;
    logic                  issue;
    logic                  q_push, q_pop, q_empty;
    logic [EntryW-1:0]     q_wdata, q_rdata;
    logic [CntW-1:0]       q_count;

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:   state_d = StRun;
            StRun:    if (halt) state_d = StHalted;
            StHalted: if (!halt) state_d = StRun;
            default:  state_d = StBoot;
        endcase
    end

    // Request generation and fetch_pc update
    always_comb begin
        jump      = redirect && is_jump_sel(pc_sel);
        target    = (pc_sel == PcAlu) ? alu_addr : imm_addr;
        req_addr  = jump ? target : fetch_pc_q;
        // In-flight response already owns a queue slot, so count it.
        occupancy = (CntW + 1)'(q_count) + (CntW + 1)'(in_flight_q);
        // A redirect discards queue and in-flight data, so space is guaranteed.
        issue     = (state_q == StRun) && (jump || (occupancy < (CntW + 1)'(QUEUE_DEPTH)));

        fetch_pc_d = fetch_pc_q;
        if (issue) begin
            fetch_pc_d = req_addr + ADDR_WIDTH'(1);
        end else if (jump) begin
            // Not issuing (boot/halted): resume fetching at the target itself.
            fetch_pc_d = target;
        end
        in_flight_d = issue;
        tag_d       = issue ? req_addr : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBoot;
            fetch_pc_q  <= ADDR_WIDTH'(RESET_PC);
            in_flight_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            in_flight_q <= in_flight_d;
            tag_q       <= tag_d;
        end
    end

    // Response arriving in a redirect cycle belongs to the old stream.
    assign q_push  = in_flight_q && !jump;
    assign q_wdata = {tag_q, bus.imem_rdata};
    assign q_pop   = bus.instr_ready && !q_empty;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EntryW)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (jump),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_rdata),
        .count (q_count),
        .empty (q_empty)
    );

    always_comb begin
        bus.imem_req    = issue;
        bus.imem_addr   = req_addr;
        bus.instr_valid = !q_empty;
        // Gate with valid so stale storage never shows when the queue is empty.
        bus.instr_data  = q_empty ? '0 : q_rdata[DATA_WIDTH-1:0];
        bus.instr_pc    = q_empty ? '0 : q_rdata[EntryW-1:DATA_WIDTH];
        queue_count     = q_count;
    end

endmodule
